// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding and controller states.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between an operand source and the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [1:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;
    logic                 zero;
    logic                 carry;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero, carry
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero, carry
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles per operation.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    // The last step's sum is the full product; the controller captures it on the same edge.
    assign done    = busy_reg && (cnt_reg == CNT_W'(1));
    assign product = acc_next;
    assign busy    = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= CNT_W'(WIDTH);
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered add/mul/xor/xnor ALU with valid/ready handshakes; one operation in flight.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_if.slave     bus
);
    localparam int YW = 2 * WIDTH;

    state_t          state_reg, state_next;
    logic [YW-1:0]   y_reg, y_next;
    logic            zero_reg, zero_next;
    logic            carry_reg, carry_next;

    logic            mul_start;
    logic            mul_busy;
    logic            mul_done;
    logic [YW-1:0]   mul_product;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] xor_w;
    logic [WIDTH-1:0] xnor_w;
    logic [YW-1:0]    alu_res;

    assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
    assign xor_w  = bus.a ^ bus.b;
    assign xnor_w = ~(bus.a ^ bus.b);

    // Results are padded explicitly so xnor never inverts the upper half.
    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, xor_w};
            OP_XNOR: alu_res = {{WIDTH{1'b0}}, xnor_w};
            default: alu_res = {{(WIDTH-1){1'b0}}, sum};
        endcase
    end

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            y_reg     <= '0;
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            zero_reg  <= zero_next;
            carry_reg <= carry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        zero_next  = zero_reg;
        carry_next = carry_reg;
        mul_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = MUL;
                    end else begin
                        y_next     = alu_res;
                        zero_next  = (alu_res == '0);
                        carry_next = (bus.op == OP_ADD) && sum[WIDTH];
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    y_next     = mul_product;
                    zero_next  = (mul_product == '0);
                    carry_next = 1'b0;
                    state_next = DONE;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; recover rather than hang.
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.y         = y_reg;
    assign bus.zero      = zero_reg;
    assign bus.carry     = carry_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=4) with a transaction-level reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_y(input int ma, input int mb, input logic [1:0] mop);
        case (mop)
            OP_ADD:  return ma + mb;
            OP_MUL:  return ma * mb;
            OP_XOR:  return ma ^ mb;
            default: return (~(ma ^ mb)) & MASK;
        endcase
    endfunction

    function automatic bit model_c(input int ma, input int mb, input logic [1:0] mop);
        return (mop == OP_ADD) && ((ma + mb) > MASK);
    endfunction

    // Reference model: idle / waiting m_wait more edges / result held.
    int   m_wait  = 0;
    bit   m_valid = 1'b0;
    int   m_y     = 0;
    bit   m_c     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait  <= 0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (bus.out_ready) m_valid <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (bus.in_valid) begin
            m_y <= model_y(int'(bus.a), int'(bus.b), bus.op);
            m_c <= model_c(int'(bus.a), int'(bus.b), bus.op);
            if (bus.op == OP_MUL) m_wait <= W;
            else                  m_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_y", 32'(bus.y), 32'd0);
            chk("rst_zero", 32'(bus.zero), 32'd0);
            chk("rst_carry", 32'(bus.carry), 32'd0);
        end else begin
            chk("mdl_in_ready", 32'(bus.in_ready), 32'(!m_valid && (m_wait == 0)));
            chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("mdl_y", 32'(bus.y), 32'(m_y));
                chk("mdl_zero", 32'(bus.zero), 32'(m_y == 0));
                chk("mdl_carry", 32'(bus.carry), 32'(m_c));
            end
        end
    end

    // Issue one op, measure latency, optionally stall the result for hold cycles.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input logic [1:0] top,
                          input logic [7:0] ey, input logic ec, input int elat, input int hold);
        int n;
        chk("pre_in_ready", 32'(bus.in_ready), 32'd1);
        bus.a         = ta;
        bus.b         = tbv;
        bus.op        = top;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = ~ta;
        bus.b        = ~tbv;
        n = 1;
        while (!bus.out_valid && n <= 20) begin
            @(posedge clk); #1;
            n++;
        end
        $display("op=%0d a=%0h b=%0h y=%0h zero=%0b carry=%0b latency=%0d hold=%0d",
                 top, ta, tbv, bus.y, bus.zero, bus.carry, n, hold);
        chk("latency", 32'(n), 32'(elat));
        chk("y", 32'(bus.y), 32'(ey));
        chk("carry", 32'(bus.carry), 32'(ec));
        chk("zero", 32'(bus.zero), 32'(ey == 8'h00));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 4'd1;
            bus.b        = 4'd1;
            bus.op       = OP_ADD;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_y", 32'(bus.y), 32'(ey));
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init_in_ready", 32'(bus.in_ready), 32'd1);
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_y", 32'(bus.y), 32'd0);
        chk("init_zero", 32'(bus.zero), 32'd0);
        chk("init_carry", 32'(bus.carry), 32'd0);

        run_op(4'd9,  4'd8,  OP_ADD,  8'h11, 1'b1, 1, 0);
        run_op(4'd0,  4'd0,  OP_ADD,  8'h00, 1'b0, 1, 0);
        run_op(4'd15, 4'd15, OP_ADD,  8'h1E, 1'b1, 1, 0);
        run_op(4'd15, 4'd15, OP_MUL,  8'hE1, 1'b0, 5, 0);
        run_op(4'd7,  4'd0,  OP_MUL,  8'h00, 1'b0, 5, 0);
        run_op(4'hA,  4'h6,  OP_XOR,  8'h0C, 1'b0, 1, 0);
        run_op(4'hA,  4'h6,  OP_XNOR, 8'h03, 1'b0, 1, 0);
        run_op(4'd5,  4'd3,  OP_MUL,  8'h0F, 1'b0, 5, 4);
        run_op(4'd2,  4'd3,  OP_ADD,  8'h05, 1'b0, 1, 0);

        // Reset in the middle of a multiply.
        bus.a         = 4'd13;
        bus.b         = 4'd11;
        bus.op        = OP_MUL;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("mid_mul_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_y", 32'(bus.y), 32'd0);
        chk("async_zero", 32'(bus.zero), 32'd0);
        chk("async_carry", 32'(bus.carry), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd3, 4'd4, OP_ADD, 8'h07, 1'b0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
